// File: rtl/min_broadcast_expand_pkg.sv
// Shared types and defaults for the min-broadcast expander and its input FIFO.
package min_broadcast_expand_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Replica index width; never zero so DIM_LEN == 1 still has a legal port.
    function automatic int cnt_width(input int dim_len);
        return (dim_len > 1) ? $clog2(dim_len) : 1;
    endfunction

endpackage

// File: rtl/min_broadcast_expand_fifo2.sv
// Two-entry input FIFO used by min_broadcast_expand when MIN_BCAST_QUEUE_EN is defined.
module min_bcast_fifo2
    import min_broadcast_expand_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              wr_ptr;
    logic              do_push, do_pop;

    assign empty   = (count_q == 2'd0);
    assign full    = (count_q == 2'd2);
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A full FIFO may accept a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // When full the write slot equals the head slot, which is vacated by the pop.
    assign wr_ptr  = rd_ptr_q ^ count_q[0];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) mem_d[wr_ptr] = push_data;
        if (do_pop) rd_ptr_d = ~rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/min_broadcast_expand.sv
// Replicates each reduced input word DIM_LEN times with its position index.
// Define MIN_BCAST_QUEUE_EN to add a 2-entry input queue for gap-free groups.
module min_broadcast_expand
    import min_broadcast_expand_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int DIM_LEN = 16,
    localparam int CNT_W  = cnt_width(DIM_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_last
);

    localparam logic [CNT_W-1:0] IDX_MAX       = CNT_W'(DIM_LEN - 1);
    localparam logic             FIRST_IS_LAST = (DIM_LEN == 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;

    logic              in_hs, out_hs, group_done, slot_free;
    logic              load;
    logic [DATA_W-1:0] load_data;

    // Valid/ready: a word or replica moves on any edge where both are high;
    // valid never waits on ready, and outputs hold while valid && !ready.
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = out_valid && out_ready;
    assign group_done = out_hs && last_q;
    assign slot_free  = (state_q == IDLE) || group_done;

    assign out_valid  = (state_q == EMIT);
    assign out_data   = data_q;
    assign out_idx    = idx_q;
    assign out_last   = last_q;

`ifdef MIN_BCAST_QUEUE_EN
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_head;

    // Queued words go first; an empty queue lets the incoming word bypass it.
    assign in_ready  = !fifo_full;
    assign fifo_pop  = slot_free && !fifo_empty;
    assign fifo_push = in_hs && !(slot_free && fifo_empty);
    assign load      = slot_free && (!fifo_empty || in_hs);
    assign load_data = fifo_empty ? in_data : fifo_head;

    min_bcast_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(in_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );
`else
    assign in_ready  = (state_q == IDLE);
    assign load      = in_hs;
    assign load_data = in_data;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (load) begin
            state_d = EMIT;
            data_d  = load_data;
            idx_d   = '0;
            last_d  = FIRST_IS_LAST;
        end else if (group_done) begin
            state_d = IDLE;
            last_d  = 1'b0;
        end else if (out_hs) begin
            idx_d  = idx_q + 1'b1;
            last_d = ((idx_q + 1'b1) == IDX_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_min_broadcast_expand.sv
// Directed bench for min_broadcast_expand: DIM_LEN=4 and DIM_LEN=1 instances.
module tb_min_broadcast_expand;

`ifdef MIN_BCAST_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;

    logic        i4_valid, i4_ready, o4_valid, o4_ready, o4_last;
    logic [31:0] i4_data, o4_data;
    logic [1:0]  o4_idx;

    logic        i1_valid, i1_ready, o1_valid, o1_ready, o1_last;
    logic [31:0] i1_data, o1_data;
    logic [0:0]  o1_idx;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    int r_first, r_last, r_nrep, r_low;

    always #5 clk = ~clk;

    min_broadcast_expand #(.DATA_W(32), .DIM_LEN(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(i4_valid), .in_ready(i4_ready), .in_data(i4_data),
        .out_valid(o4_valid), .out_ready(o4_ready), .out_data(o4_data),
        .out_idx(o4_idx), .out_last(o4_last)
    );

    min_broadcast_expand #(.DATA_W(32), .DIM_LEN(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(i1_valid), .in_ready(i1_ready), .in_data(i1_data),
        .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data),
        .out_idx(o1_idx), .out_last(o1_last)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pushes src_q into the chosen DUT and scores every
    // valid replica against exp_q, one cycle per iteration.
    task automatic run_stream(input bit use1, input int max_cyc, input logic [31:0] ready_pat);
        int          dim;
        int          exp_idx;
        logic        v, rdy, lst, in_rdy;
        logic [31:0] d, ix;
        dim     = use1 ? 1 : 4;
        exp_idx = 0;
        r_first = -1;
        r_last  = -1;
        r_nrep  = 0;
        r_low   = -1;
        for (int c = 0; c < max_cyc; c++) begin
            rdy = (c < 32) ? ready_pat[c] : 1'b1;
            if (use1) begin
                o1_ready = rdy;
                v = o1_valid; d = o1_data; ix = 32'(o1_idx); lst = o1_last; in_rdy = i1_ready;
            end else begin
                o4_ready = rdy;
                v = o4_valid; d = o4_data; ix = 32'(o4_idx); lst = o4_last; in_rdy = i4_ready;
            end
            if (c > 0 && !in_rdy && r_low < 0) r_low = c;
            if (src_q.size() > 0) begin
                if (use1) begin i1_valid = 1'b1; i1_data = src_q[0]; end
                else      begin i4_valid = 1'b1; i4_data = src_q[0]; end
                if (in_rdy) exp_q.push_back(src_q.pop_front());
            end else begin
                if (use1) i1_valid = 1'b0;
                else      i4_valid = 1'b0;
            end
            if (v) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", 32'(v), 32'd0);
                end else begin
                    check_eq("rep_data", d, exp_q[0]);
                    check_eq("rep_idx", ix, 32'(exp_idx));
                    check_eq("rep_last", 32'(lst), 32'(exp_idx == dim - 1));
                    if (r_first < 0) r_first = c;
                    r_last = c;
                    if (rdy) begin
                        r_nrep++;
                        exp_idx++;
                        if (exp_idx == dim) begin
                            exp_idx = 0;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
            @(negedge clk);
        end
        i1_valid = 1'b0;
        i4_valid = 1'b0;
        o1_ready = 1'b1;
        o4_ready = 1'b1;
        check_eq("drained_exp", 32'(exp_q.size()), 32'd0);
        check_eq("drained_src", 32'(src_q.size()), 32'd0);
        exp_q.delete();
        src_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        i4_valid = 1'b0; i4_data = '0; o4_ready = 1'b1;
        i1_valid = 1'b0; i1_data = '0; o1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state, first cycle after deassertion
        check_eq("rst4_in_ready", 32'(i4_ready), 32'd1);
        check_eq("rst4_out_valid", 32'(o4_valid), 32'd0);
        check_eq("rst4_out_data", o4_data, 32'd0);
        check_eq("rst4_out_idx", 32'(o4_idx), 32'd0);
        check_eq("rst4_out_last", 32'(o4_last), 32'd0);
        check_eq("rst1_in_ready", 32'(i1_ready), 32'd1);
        check_eq("rst1_out_valid", 32'(o1_valid), 32'd0);

        // Basic group, latency 1
        src_q = '{32'hFFFF_FFF0};
        run_stream(1'b0, 8, 32'hFFFF_FFFF);
        check_eq("basic_first", 32'(r_first), 32'd1);
        check_eq("basic_last", 32'(r_last), 32'd4);
        check_eq("basic_nrep", 32'(r_nrep), 32'd4);

        // Backpressure 1,0,0,1 during the group
        src_q = '{32'hA5A5_0001};
        run_stream(1'b0, 10, 32'hFFFF_FFF3);
        check_eq("bp_last", 32'(r_last), 32'd6);
        check_eq("bp_nrep", 32'(r_nrep), 32'd4);

        // Back-to-back words
        src_q = '{32'h5, 32'h7};
        run_stream(1'b0, 12, 32'hFFFF_FFFF);
        check_eq("b2b_first", 32'(r_first), 32'd1);
        check_eq("b2b_last", 32'(r_last), QEN ? 32'd8 : 32'd9);
        check_eq("b2b_nrep", 32'(r_nrep), 32'd8);

        // DIM_LEN == 1
        src_q = '{32'h1, 32'h2, 32'h3};
        run_stream(1'b1, 8, 32'hFFFF_FFFF);
        check_eq("dim1_first", 32'(r_first), 32'd1);
        check_eq("dim1_last", 32'(r_last), QEN ? 32'd3 : 32'd5);
        check_eq("dim1_nrep", 32'(r_nrep), 32'd3);

        // Stalled output while three words arrive
        src_q = '{32'h11, 32'h22, 32'h33};
        run_stream(1'b0, 24, 32'hFFFF_FFC0);
        check_eq("qfull_ready_low", 32'(r_low), QEN ? 32'd3 : 32'd1);
        check_eq("qfull_last", 32'(r_last), QEN ? 32'd17 : 32'd19);
        check_eq("qfull_nrep", 32'(r_nrep), 32'd12);

        // Reset in the middle of a group
        i4_valid = 1'b1; i4_data = 32'hBEEF_0001; o4_ready = 1'b1;
        check_eq("mid_in_ready", 32'(i4_ready), 32'd1);
        @(negedge clk);
        i4_data = 32'hBEEF_0002;
        @(negedge clk);
        i4_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_pre_valid", 32'(o4_valid), 32'd1);
        check_eq("mid_pre_idx", 32'(o4_idx), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_out_valid", 32'(o4_valid), 32'd0);
        check_eq("mid_out_data", o4_data, 32'd0);
        check_eq("mid_out_idx", 32'(o4_idx), 32'd0);
        check_eq("mid_out_last", 32'(o4_last), 32'd0);
        check_eq("mid_in_ready_post", 32'(i4_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | o4_valid;
        end
        check_eq("mid_no_stale", 32'(seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/min_broadcast_expand.md
MIN_BROADCAST_EXPAND -- requirements
Module: min_broadcast_expand

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element width.
REQ-002 SHALL have parameter DIM_LEN, default 16, number of replicas emitted per input word; legal range 1..65535.
REQ-003 SHALL derive localparam CNT_W = max(1, $clog2(DIM_LEN)).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream word valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a word.
REQ-008 SHALL have port in_data  input  DATA_W  reduced (min) value to expand.
REQ-009 SHALL have port out_valid  output  1  replica valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts replica.
REQ-011 SHALL have port out_data  output  DATA_W  replica value.
REQ-012 SHALL have port out_idx  output  CNT_W  position of replica along the expanded dimension.
REQ-013 SHALL have port out_last  output  1  high on the replica with out_idx == DIM_LEN-1.

Function
REQ-014 SHALL transfer on an input handshake when in_valid && in_ready, and on an output handshake when out_valid && out_ready.
REQ-015 SHALL implement an FSM with states IDLE (no word held) and EMIT (word held, replicas pending).
REQ-016 SHALL move IDLE->EMIT on an input handshake, latch in_data, and clear the index to 0.
REQ-017 SHALL assert out_valid in EMIT only, with first replica valid in the cycle after the input handshake (latency 1).
REQ-018 SHALL increment out_idx by 1 on each output handshake while out_idx < DIM_LEN-1.
REQ-019 SHALL, on the output handshake with out_last high, return to IDLE, or load the next queued word (REQ-030) and remain in EMIT.
REQ-020 SHALL hold out_data, out_idx, out_last stable while out_valid && !out_ready.
REQ-021 SHALL, for DIM_LEN == 1, assert out_last on every replica and emit exactly one replica per input word.
REQ-022 SHALL never drop, duplicate or reorder input words; replica values equal the latched word bit-exactly.
REQ-023 SHALL drive in_ready purely from registered state (no combinational path from out_ready or in_valid).

Reset
REQ-024 SHALL, with rst high at a clock edge, enter IDLE and clear out_valid, out_last, out_idx, and out_data to 0.
REQ-025 SHALL, on reset mid-EMIT, discard the held word and all queued words with no further replicas emitted.
REQ-026 SHALL, in the first cycle after reset deassertion, present in_ready = 1 and out_valid = 0.

Configuration
REQ-027 SHALL support macro MIN_BCAST_QUEUE_EN.
REQ-028 SHALL, without MIN_BCAST_QUEUE_EN, drive in_ready = (state == IDLE); one idle cycle separates consecutive groups.
REQ-029 SHALL, with MIN_BCAST_QUEUE_EN, add a 2-entry input FIFO with in_ready = !fifo_full.
REQ-030 SHALL, with MIN_BCAST_QUEUE_EN, on the last-replica handshake with the FIFO non-empty, pop the head into the emit register so the next group's idx 0 appears in the following cycle (zero bubbles).
REQ-031 SHALL, with MIN_BCAST_QUEUE_EN, handle simultaneous push and pop in one cycle without loss, including push to a full FIFO that is popping.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, EMIT) and the DATA_W default in the shared operator package.
REQ-033 SHALL implement the FIFO as sub-module min_bcast_fifo2, instantiated only under MIN_BCAST_QUEUE_EN.

Verification
REQ-034 Basic: DIM_LEN=4, push 0xFFFF_FFF0, out_ready=1 -> 4 replicas 0xFFFF_FFF0, idx 0..3, out_last only on idx 3, first at T+1.
REQ-035 Backpressure: out_ready toggles 1,0,0,1 during a group -> outputs held while stalled, no idx skipped or repeated.
REQ-036 Back-to-back: push 0x5 then 0x7 continuously -> without macro 1 idle cycle between groups, with macro 0 idle cycles, 8 replicas total in order.
REQ-037 DIM_LEN=1: push 3 words 0x1,0x2,0x3 -> 3 replicas, each out_last=1, out_idx=0.
REQ-038 Reset mid-group: rst at idx 2 of 4 -> next cycle out_valid=0, outputs 0, in_ready=1, no stale replica after reset.
REQ-039 Queue full (macro on): stall out_ready=0, push 3 words -> in_ready low after 2 queued, all 3 groups later emitted in order.
